// File: rtl/aes_dec_ctrl_if.sv
// aes_dec_ctrl_if: key-load, block-in and block-out handshakes of the AES-128 decryption controller
interface aes_dec_ctrl_if;
  logic [127:0] key_in;
  logic key_load;
  logic key_ready;
  logic [127:0] din;
  logic din_valid;
  logic din_ready;
  logic [127:0] dout;
  logic dout_valid;
  logic dout_ready;
  logic busy;
  modport master(output key_in, key_load, din, din_valid, dout_ready, input key_ready, din_ready, dout, dout_valid, busy);
  modport slave(input key_in, key_load, din, din_valid, dout_ready, output key_ready, din_ready, dout, dout_valid, busy);
endinterface

// File: rtl/aes_dec_ctrl.sv
// aes_dec_ctrl: AES-128 iterative decryption sequencer with forward key expansion and cached last round key
module aes_dec_ctrl (
  input logic clk,
  input logic rst,
  aes_dec_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, KEXP, READY, KREW, ROUND, OUT} state_t;
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, p;
    r = '0;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ p;
      p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction
  // Field inverse as a^254 by repeated squaring; maps 0 to 0 as the S-box needs
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction
  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction
  function automatic logic [7:0] isbox(input logic [7:0] x);
    return ginv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
  endfunction
  function automatic logic [31:0] subrot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction
  function automatic logic [7:0] rcon(input logic [9:0] s);
    logic [7:0] r;
    r = (s[8] ? 8'h1b : 8'h00) | (s[9] ? 8'h36 : 8'h00);
    for (int i = 0; i < 8; i++) if (s[i]) r = r | 8'(1 << i);
    return r;
  endfunction
  function automatic logic [127:0] fwd_next(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ subrot(k[31:0]) ^ {rc, 24'h0};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction
  function automatic logic [127:0] inv_prev(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] p3;
    p3 = k[31:0] ^ k[63:32];
    return {k[127:96] ^ subrot(p3) ^ {rc, 24'h0}, k[95:64] ^ k[127:96], k[63:32] ^ k[95:64], p3};
  endfunction
  function automatic logic [7:0] byte_of(input logic [127:0] x, input int i);
    return x[127-8*i -: 8];
  endfunction
  function automatic logic [127:0] imc(input logic [127:0] x);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127-8*(4*c+w) -: 8] = gmul(8'h0e, byte_of(x, 4*c + (w & 3))) ^ gmul(8'h0b, byte_of(x, 4*c + ((w+1) & 3)))
                              ^ gmul(8'h0d, byte_of(x, 4*c + ((w+2) & 3))) ^ gmul(8'h09, byte_of(x, 4*c + ((w+3) & 3)));
    return r;
  endfunction
  // InvMixColumns is applied on entry, so the first round after the k10 whitening skips it
  function automatic logic [127:0] dec_round(input logic [127:0] di, input logic [127:0] ki, input logic skip);
    logic [127:0] t, r;
    t = skip ? di : imc(di);
    r = '0;
    for (int i = 0; i < 16; i++)
      r[127-8*i -: 8] = isbox(byte_of(t, 4*(((i >> 2) - (i & 3)) & 3) + (i & 3))) ^ byte_of(ki, i);
    return r;
  endfunction
  state_t state;
  logic [127:0] dat, key, k10, kn, ko, rd;
  logic [9:0] rrg, kr;
  assign kn = fwd_next(key, rcon(kr));
  assign ko = inv_prev(key, rcon(rrg));
  assign rd = dec_round(dat, key, rrg[8]);
  assign bus.dout = dat;
  assign bus.dout_valid = state == OUT;
  assign bus.din_ready = state == READY && !bus.key_load;
  assign bus.busy = state == KEXP || state == KREW || state == ROUND;
  assign bus.key_ready = state == READY || state == KREW || state == ROUND || state == OUT;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dat <= '0;
      key <= '0;
      k10 <= '0;
      rrg <= '0;
      kr <= '0;
    end else begin
      case (state)
        IDLE, READY: begin
          if (bus.key_load) begin
            key <= bus.key_in;
            kr <= 10'b1;
            state <= KEXP;
          end else if (state == READY && bus.din_valid) begin
            dat <= bus.din ^ k10;
            key <= k10;
            rrg <= 10'b10_0000_0000;
            state <= KREW;
          end
        end
        KEXP: begin
          key <= kn;
          kr <= kr << 1;
          if (kr[9]) begin
            k10 <= kn;
            state <= READY;
          end
        end
        KREW: begin
          key <= ko;
          rrg <= rrg >> 1;
          state <= ROUND;
        end
        ROUND: begin
          dat <= rd;
          key <= ko;
          rrg <= rrg >> 1;
          if (rrg == '0) state <= OUT;
        end
        OUT: if (bus.dout_ready) state <= READY;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
